// File: rtl/drive_mode_arbiter_pkg.sv
// Shared types and motor-byte layout for the drive mode arbiter.
// Byte: [7:5] left speed, [4] left dir, [3:1] right speed, [0] right dir.
package drive_mode_arbiter_pkg;

   localparam int LSPD = 5;
   localparam int LDIR = 4;
   localparam int RSPD = 1;
   localparam int RDIR = 0;

   localparam logic [7:0] MOT_STOP = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      DECODE = 2'd2
   } poll_st_t;

   typedef enum logic {
      AUTO   = 1'b0,
      MANUAL = 1'b1
   } mode_t;

   typedef struct packed {
      logic fwd;
      logic back;
      logic left;
      logic right;
   } dir_t;

   function automatic logic [7:0] mot_byte(
      input logic [2:0] ls,
      input logic       ld,
      input logic [2:0] rs,
      input logic       rd
   );
      logic [7:0] b;
      b            = MOT_STOP;
      b[LSPD +: 3] = ls;
      b[LDIR]      = ld;
      b[RSPD +: 3] = rs;
      b[RDIR]      = rd;
      return b;
   endfunction

endpackage

// File: rtl/drive_mode_arbiter_if.sv
// Bus between the arbiter and its PicoBlaze / PmodJSTK / bot neighbours.
// slave = arbiter side, master = system side.
interface drive_mode_arbiter_if;

   logic [7:0] auto_motctl;
   logic       ovr_en;
   logic       poll_done;
   logic [9:0] jstk_x;
   logic [9:0] jstk_y;
   logic [2:0] jstk_btn;
   logic       poll_req;
   logic [7:0] motctl_out;
   logic       manual;
   logic       poll_err;
   logic [3:0] dir_led;

   modport master (
      output auto_motctl, ovr_en, poll_done,
      output jstk_x, jstk_y, jstk_btn,
      input  poll_req, motctl_out, manual,
      input  poll_err, dir_led
   );

   modport slave (
      input  auto_motctl, ovr_en, poll_done,
      input  jstk_x, jstk_y, jstk_btn,
      output poll_req, motctl_out, manual,
      output poll_err, dir_led
   );

endinterface

// File: rtl/drive_mode_arbiter_jstk_dir_decode.sv
// Maps stick position to direction flags and the manual motor byte.
// On a diagonal the wheel on the deflected side stops and the other drives.
module jstk_dir_decode
   import drive_mode_arbiter_pkg::*;
#(
   parameter int JOY_HI    = 700,
   parameter int JOY_LO    = 300,
   parameter int MAN_SPEED = 5
) (
   input  logic [9:0] x,
   input  logic [9:0] y,
   output dir_t       dir,
   output logic [7:0] cmd
);

   localparam logic [2:0] S = 3'(MAN_SPEED);
   localparam logic [2:0] Z = 3'd0;

   always_comb begin
      dir.fwd   = y >= 10'(JOY_HI);
      dir.back  = y <= 10'(JOY_LO);
      dir.right = x >= 10'(JOY_HI);
      dir.left  = x <= 10'(JOY_LO);
   end

   always_comb begin
      cmd = MOT_STOP;
      case (dir)
         4'b1000: cmd = mot_byte(S, 1'b1, S, 1'b1);
         4'b0100: cmd = mot_byte(S, 1'b0, S, 1'b0);
         4'b0010: cmd = mot_byte(S, 1'b0, S, 1'b1);
         4'b0001: cmd = mot_byte(S, 1'b1, S, 1'b0);
         4'b1010: cmd = mot_byte(Z, 1'b0, S, 1'b1);
         4'b1001: cmd = mot_byte(S, 1'b1, Z, 1'b0);
         4'b0110: cmd = mot_byte(Z, 1'b0, S, 1'b0);
         4'b0101: cmd = mot_byte(S, 1'b0, Z, 1'b0);
         default: cmd = MOT_STOP;
      endcase
   end

endmodule

// File: rtl/drive_mode_arbiter.sv
// Schedules PmodJSTK polls and owns the bot motor byte, switching between
// PicoBlaze AUTO drive and joystick MANUAL drive.
module drive_mode_arbiter
   import drive_mode_arbiter_pkg::*;
#(
   parameter int POLL_DIV      = 13000000,
   parameter int POLL_TIMEOUT  = 65000,
   parameter int NEUTRAL_POLLS = 10,
   parameter int JOY_HI        = 700,
   parameter int JOY_LO        = 300,
   parameter int MAN_SPEED     = 5
) (
   input logic                 clk,
   input logic                 reset,
   drive_mode_arbiter_if.slave bus
);

   localparam int DW = $clog2(POLL_DIV + 1);
   localparam int TW = $clog2(POLL_TIMEOUT + 1);
   localparam int NW = $clog2(NEUTRAL_POLLS + 1);

   poll_st_t      state, state_nx;
   mode_t         mode, mode_nx;
   logic [DW-1:0] div_cnt;
   logic [TW-1:0] to_cnt;
   logic [NW-1:0] ntr_cnt, ntr_nx;
   logic [9:0]    cap_x, cap_y;
   logic          cap_trig;
   logic [7:0]    man_cmd, man_nx, dec_cmd, motctl;
   logic [3:0]    dir_led;
   logic          poll_req, poll_err;
   dir_t          dir;
   logic          tick, t_out, fire, take, fail, dec, neutral;
   logic          unused_btn;

   assign unused_btn = ^bus.jstk_btn[2:1];
   assign tick  = div_cnt == DW'(POLL_DIV - 1);
   assign t_out = to_cnt == TW'(POLL_TIMEOUT - 1);

   jstk_dir_decode #(
      .JOY_HI   (JOY_HI),
      .JOY_LO   (JOY_LO),
      .MAN_SPEED(MAN_SPEED)
   ) u_dec (
      .x  (cap_x),
      .y  (cap_y),
      .dir(dir),
      .cmd(dec_cmd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (tick) state_nx = WAIT;
         WAIT: begin
            if (bus.poll_done) state_nx = DECODE;
            else if (t_out)    state_nx = IDLE;
         end
         DECODE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      fire = (state == IDLE) && tick;
      take = (state == WAIT) && bus.poll_done;
      fail = (state == WAIT) && !bus.poll_done && t_out;
      dec  = (state == DECODE);
   end

   // Mode decisions only happen in DECODE, except the override switch.
   always_comb begin
      mode_nx = mode;
      ntr_nx  = ntr_cnt;
      man_nx  = man_cmd;
      neutral = (dir == '0);
      if (dec) begin
         man_nx = dec_cmd;
         if (mode == AUTO) begin
            if (bus.ovr_en && (!neutral || cap_trig)) begin
               mode_nx = MANUAL;
               ntr_nx  = '0;
            end
         end else if (!neutral) begin
            ntr_nx = '0;
         end else if (ntr_cnt == NW'(NEUTRAL_POLLS - 1)) begin
            mode_nx = AUTO;
            ntr_nx  = '0;
         end else begin
            ntr_nx = ntr_cnt + 1'b1;
         end
      end
      if (fail) man_nx = MOT_STOP;
      if (!bus.ovr_en) begin
         mode_nx = AUTO;
         ntr_nx  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt  <= '0;
         to_cnt   <= '0;
         poll_req <= 1'b0;
         poll_err <= 1'b0;
         cap_x    <= '0;
         cap_y    <= '0;
         cap_trig <= 1'b0;
         dir_led  <= '0;
         mode     <= AUTO;
         ntr_cnt  <= '0;
         man_cmd  <= MOT_STOP;
         motctl   <= MOT_STOP;
      end else begin
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         to_cnt   <= (state == WAIT) ? to_cnt + 1'b1 : '0;
         poll_req <= fire;
         if (fail) poll_err <= 1'b1;
         if (take) begin
            cap_x    <= bus.jstk_x;
            cap_y    <= bus.jstk_y;
            cap_trig <= bus.jstk_btn[0];
         end
         if (dec) dir_led <= dir;
         mode    <= mode_nx;
         ntr_cnt <= ntr_nx;
         man_cmd <= man_nx;
         // A source change always passes through one stop cycle.
         if (mode_nx != mode)       motctl <= MOT_STOP;
         else if (mode_nx == MANUAL) motctl <= man_nx;
         else                        motctl <= bus.auto_motctl;
      end
   end

   assign bus.poll_req   = poll_req;
   assign bus.poll_err   = poll_err;
   assign bus.dir_led    = dir_led;
   assign bus.manual     = (mode == MANUAL);
   assign bus.motctl_out = motctl;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed + randomized bench for drive_mode_arbiter against a
// time-window reference model of polling, decode and mode rules.
module tb_drive_mode_arbiter;

   localparam int DIV = 100;
   localparam int TMO = 40;
   localparam int NP  = 3;
   localparam int HI  = 700;
   localparam int LO  = 300;
   localparam int SPD = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   drive_mode_arbiter_if bus();

   drive_mode_arbiter #(
      .POLL_DIV     (DIV),
      .POLL_TIMEOUT (TMO),
      .NEUTRAL_POLLS(NP),
      .JOY_HI       (HI),
      .JOY_LO       (LO),
      .MAN_SPEED    (SPD)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: n = clock edges since reset release.
   int         n = 0;
   int         ws = -1;
   int         dec_at = -1;
   bit         m_mode = 0;
   int         nrun = 0;
   logic [7:0] m_man = 8'h00;
   logic [9:0] cx = 0, cy = 0;
   bit         ctrig = 0;
   bit         e_req = 0;
   bit         e_err = 0;
   logic [7:0] e_mot = 8'h00;
   logic [3:0] e_led = 4'h0;

   function automatic logic [7:0] ref_cmd(input int x, input int y);
      bit f, b, l, r;
      int ls, rs, ld, rd;
      f = y >= HI; b = y <= LO; r = x >= HI; l = x <= LO;
      ls = 0; rs = 0; ld = 0; rd = 0;
      if ((f || b) && !(l || r)) begin
         ls = SPD; rs = SPD; ld = f; rd = f;
      end else if (!(f || b) && (l || r)) begin
         ls = SPD; rs = SPD; ld = r; rd = l;
      end else if ((f || b) && (l || r)) begin
         if (l) begin rs = SPD; rd = f; end
         else   begin ls = SPD; ld = f; end
      end
      return 8'(ls * 32 + ld * 16 + rs * 2 + rd);
   endfunction

   task automatic model_reset();
      n = 0; ws = -1; dec_at = -1; m_mode = 0; nrun = 0;
      m_man = 8'h00; e_req = 0; e_err = 0; e_mot = 8'h00; e_led = 4'h0;
   endtask

   task automatic model_step();
      bit nm, neu;
      int xi, yi;
      n++;
      e_req = 0;
      nm = m_mode;
      if (dec_at == n) begin
         dec_at = -1;
         xi = int'(cx); yi = int'(cy);
         e_led = {yi >= HI, yi <= LO, xi <= LO, xi >= HI};
         m_man = ref_cmd(xi, yi);
         neu = (e_led == 4'h0);
         if (!m_mode) begin
            if (bus.ovr_en && (!neu || ctrig)) begin nm = 1; nrun = 0; end
         end else if (neu) begin
            nrun++;
            if (nrun == NP) begin nm = 0; nrun = 0; end
         end else nrun = 0;
      end else if (ws >= 0) begin
         if (bus.poll_done) begin
            cx = bus.jstk_x; cy = bus.jstk_y; ctrig = bus.jstk_btn[0];
            dec_at = n + 1; ws = -1;
         end else if (n - ws == TMO) begin
            e_err = 1; m_man = 8'h00; ws = -1;
         end
      end else if (n % DIV == 0) begin
         e_req = 1; ws = n;
      end
      if (!bus.ovr_en) begin nm = 0; nrun = 0; end
      e_mot = (nm != m_mode) ? 8'h00 : (nm ? m_man : bus.auto_motctl);
      m_mode = nm;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      checks++;
      if ({bus.poll_req, bus.motctl_out, bus.manual, bus.poll_err, bus.dir_led}
          !== {e_req, e_mot, m_mode, e_err, e_led}) begin
         errors++;
         $display("FAIL model n=%0d: got req=%b mot=%h man=%b err=%b led=%b expected req=%b mot=%h man=%b err=%b led=%b",
                  n, bus.poll_req, bus.motctl_out, bus.manual, bus.poll_err, bus.dir_led,
                  e_req, e_mot, m_mode, e_err, e_led);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.poll_req && k < 400);
      chk("poll_req seen", 32'(bus.poll_req), 32'd1);
   endtask

   task automatic do_poll(input int x, input int y, input logic [2:0] b);
      wait_req();
      bus.poll_done = 1'b1;
      bus.jstk_x = 10'(x); bus.jstk_y = 10'(y); bus.jstk_btn = b;
      @(negedge clk);
      bus.poll_done = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [9:0] pick();
      int unsigned k;
      k = $urandom_range(0, 11);
      case (k)
         0: return 10'd0;
         1: return 10'd100;
         2: return 10'd299;
         3: return 10'd300;
         4: return 10'd301;
         5: return 10'd512;
         6: return 10'd699;
         7: return 10'd700;
         8: return 10'd701;
         9: return 10'd900;
         10: return 10'd1023;
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   initial begin
      int resp;
      bus.auto_motctl = 8'h00; bus.ovr_en = 1'b0; bus.poll_done = 1'b0;
      bus.jstk_x = 10'd512; bus.jstk_y = 10'd512; bus.jstk_btn = 3'b000;
      repeat (3) @(negedge clk);
      chk("reset motctl", 32'(bus.motctl_out), 32'h00);
      chk("reset flags", 32'({bus.poll_req, bus.manual, bus.poll_err, bus.dir_led}), 32'h0);
      rst_n = 1'b1;

      wait_req();
      chk("first poll cycle", n, DIV);
      while (n < DIV + TMO - 1) @(negedge clk);
      chk("no err before timeout", 32'(bus.poll_err), 32'd0);
      @(negedge clk);
      chk("err at timeout", 32'(bus.poll_err), 32'd1);
      chk("motctl unchanged", 32'(bus.motctl_out), 32'h00);

      bus.auto_motctl = 8'hA5;
      @(negedge clk);
      chk("auto follow", 32'(bus.motctl_out), 32'hA5);
      do_poll(512, 900, 3'b000);
      chk("no ovr stays auto", 32'(bus.manual), 32'd0);

      bus.ovr_en = 1'b1;
      do_poll(512, 900, 3'b000);
      chk("enter manual", 32'(bus.manual), 32'd1);
      chk("switch stop", 32'(bus.motctl_out), 32'h00);
      @(negedge clk);
      chk("fwd cmd", 32'(bus.motctl_out), 32'hBB);
      chk("fwd led", 32'(bus.dir_led), 32'b1000);

      do_poll(512, 512, 3'b000);
      do_poll(512, 512, 3'b000);
      chk("two neutral", 32'(bus.manual), 32'd1);
      do_poll(512, 100, 3'b000);
      chk("back cmd", 32'(bus.motctl_out), 32'hAA);
      do_poll(512, 512, 3'b000);
      do_poll(512, 512, 3'b000);
      chk("still manual", 32'(bus.manual), 32'd1);
      do_poll(512, 512, 3'b000);
      chk("revert auto", 32'(bus.manual), 32'd0);
      chk("revert stop", 32'(bus.motctl_out), 32'h00);
      @(negedge clk);
      chk("revert follow", 32'(bus.motctl_out), 32'hA5);

      do_poll(100, 900, 3'b000);
      chk("fwd-left manual", 32'(bus.manual), 32'd1);
      @(negedge clk);
      chk("fwd-left cmd", 32'(bus.motctl_out), 32'h0B);
      wait_req();
      bus.ovr_en = 1'b0;
      @(negedge clk);
      chk("ovr drop auto", 32'(bus.manual), 32'd0);
      chk("ovr drop stop", 32'(bus.motctl_out), 32'h00);
      @(negedge clk);
      chk("ovr drop follow", 32'(bus.motctl_out), 32'hA5);
      bus.ovr_en = 1'b1;

      do_poll(700, 512, 3'b000);
      chk("x700 led", 32'(bus.dir_led), 32'b0001);
      @(negedge clk);
      chk("right cmd", 32'(bus.motctl_out), 32'hBA);
      do_poll(699, 512, 3'b000);
      chk("x699 led", 32'(bus.dir_led), 32'b0000);
      do_poll(512, 300, 3'b000);
      chk("y300 led", 32'(bus.dir_led), 32'b0100);
      do_poll(512, 301, 3'b000);
      chk("y301 led", 32'(bus.dir_led), 32'b0000);
      bus.poll_done = 1'b1; bus.jstk_y = 10'd900;
      @(negedge clk);
      bus.poll_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle done ignored", 32'(bus.dir_led), 32'b0000);

      resp = -1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bus.poll_done = 1'b0;
         if ($urandom_range(0, 3) == 0) bus.auto_motctl = 8'($urandom);
         if ($urandom_range(0, 149) == 0) bus.ovr_en = ~bus.ovr_en;
         if (bus.poll_req) resp = $urandom_range(0, 48);
         if (resp == 0) begin
            bus.poll_done = 1'b1;
            bus.jstk_x = pick(); bus.jstk_y = pick();
            bus.jstk_btn = 3'($urandom);
            resp = -1;
         end else if (resp > 0) begin
            resp--;
         end else if ($urandom_range(0, 79) == 0) begin
            bus.poll_done = 1'b1;
            bus.jstk_y = pick();
         end
      end
      @(negedge clk);
      bus.poll_done = 1'b0;

      wait_req();
      #3 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_req();
      chk("poll after reset", n, DIV);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/drive_mode_arbiter.md
Name: drive_mode_arbiter

Overview:
- Owns the Rojobot motor-control byte. Selects between the PicoBlaze autonomous command and manual joystick drive.
- Schedules periodic PmodJSTK polls and decodes deflection into a motor command.
- Enters manual override on operator request and returns to autonomous after sustained neutral stick or switch release.
- Sits between the PicoBlaze PORT_09 output, the PmodJSTK SPI block and the bot MotCtl_in input.

Parameters:
POLL_DIV, 13000000, sysclk cycles between poll requests (5 Hz at 65 MHz)
POLL_TIMEOUT, 65000, cycles to wait for poll_done before declaring a failed poll
NEUTRAL_POLLS, 10, consecutive neutral polls in MANUAL before reverting to AUTO
JOY_HI, 700, axis value at or above this means positive deflection
JOY_LO, 300, axis value at or below this means negative deflection
MAN_SPEED, 5, 3-bit speed used for manual drive

Ports:
clk  input  1  system clock (sysclk)
reset  input  1  asynchronous, active-low reset
auto_motctl  input  8  PicoBlaze motor command
ovr_en  input  1  debounced override-enable switch
poll_done  input  1  one-cycle pulse; jstk_x/jstk_y/jstk_btn valid this cycle
jstk_x  input  10  joystick X
jstk_y  input  10  joystick Y
jstk_btn  input  3  joystick buttons; [0] = trigger
poll_req  output  1  one-cycle pulse starting an SPI poll (sndRec)
motctl_out  output  8  command to bot MotCtl_in
manual  output  1  1 = MANUAL mode
poll_err  output  1  sticky; set on poll timeout
dir_led  output  4  registered {fwd,back,left,right} from last good poll

Behaviour:
- Reset: all outputs 0; FSM IDLE; mode AUTO; counters 0; motctl_out = 8'h00 (stop).
- Motor byte format: [7:5] left speed, [4] left dir (1 = fwd), [3:1] right speed, [0] right dir.
- Poll FSM:
  - IDLE: divider counts to POLL_DIV-1, then poll_req=1 for one cycle and go to WAIT.
  - WAIT: poll_done -> capture inputs, go to DECODE. Timeout counter reaching POLL_TIMEOUT -> set poll_err, go to IDLE.
  - DECODE: one cycle; update dir_led, mode and motor command; go to IDLE.
  - Divider keeps running in every state; a period expiring outside IDLE is dropped, never queued.
  - poll_done outside WAIT is ignored.
- Decode (inclusive thresholds):
  - fwd = y>=JOY_HI; back = y<=JOY_LO; right = x>=JOY_HI; left = x<=JOY_LO.
  - fwd and back are exclusive by construction.
- Manual command, with S = MAN_SPEED:
  - fwd only: both wheels S, dir 1.
  - back only: both wheels S, dir 0.
  - left only: left S dir 0, right S dir 1.
  - right only: mirror of left.
  - fwd+left: left speed 0, right S dir 1. fwd+right: mirror.
  - back+left / back+right: same as fwd pairs with dir 0.
  - neutral: 8'h00.
- Mode, evaluated only in DECODE:
  - AUTO -> MANUAL when ovr_en=1 and (any deflection or jstk_btn[0]=1); neutral counter cleared.
  - In MANUAL, a neutral poll increments the neutral counter; a non-neutral poll clears it.
  - When the counter reaches NEUTRAL_POLLS, go to AUTO.
  - ovr_en=0 forces AUTO on the next clock, in any FSM state, and clears the counter.
  - A failed poll in MANUAL latches the manual command to 8'h00; the mode is unchanged.
- Output, registered:
  - AUTO: motctl_out follows auto_motctl with 1-cycle latency.
  - MANUAL: motctl_out holds the last decoded command.
  - On the mode switch: stop (8'h00) for exactly one cycle, then the new source.
- Async reset mid-poll: abandon the poll; no poll_req until a full POLL_DIV period after release.

Decomposition:
- Shared package holds:
  - motor byte field constants: LSPD, LDIR, RSPD, RDIR bit positions;
  - MOT_STOP = 8'h00;
  - poll FSM state encoding: IDLE, WAIT, DECODE;
  - mode encoding: AUTO, MANUAL.
- One natural sub-module: jstk_dir_decode. It is combinational and maps x, y and thresholds to {fwd,back,left,right} and the 8-bit manual command.
- Poll scheduler and mode FSM stay in the top of this block.

Test Plan:
- Reset release with POLL_DIV=100 and no poll_done -> poll_req pulse at cycle 100; poll_err=1 at cycle 100+POLL_TIMEOUT; motctl_out unchanged.
- ovr_en=0, auto_motctl=8'hA5 -> motctl_out=8'hA5 one cycle later; polls with y=900 do not change the mode.
- ovr_en=1, poll returns y=900, x=512 -> manual=1, stop for one cycle, then motctl_out=8'hBB, dir_led=4'b1000.
- MANUAL, then NEUTRAL_POLLS=3 polls of x=y=512 -> manual=0 after the third DECODE; an interleaved y=100 poll (neutral counter cleared) delays the revert by three more polls.
- MANUAL with x=100, y=900 -> motctl_out=8'h0B; dropping ovr_en mid-WAIT -> AUTO next clock, stop for one cycle, then follows auto_motctl.
- Boundary values: x=700 -> right; x=699 -> neutral; y=300 -> back; y=301 -> neutral. Also poll_done during IDLE is ignored.
